sudoku_scan_ctrl: RTL and testbench
===================================

# sudoku_scan_ctrl

Board-scan controller and RAM-port arbiter for the 4x4 Sudoku board RAM (4 rows × 24-bit words, 2-bit address). It shares the single RAM address port between the board editor, which has priority, and its own scan engine. The scan engine reads all four rows and checks every row, column and 2x2 box. It then reports whether the board is completely and correctly filled, and which rows failed.

## Interface
- AUTO_RESCAN, 0 — when 1, a new scan starts automatically the cycle after each `done`; when 0, scans run only on `start`.
- CLK  in  1  system clock; all state updates on the rising edge.
- RST  in  1  reset, synchronous and active-high.
- start  in  1  scan request; sampled on CLK.
- edit_req  in  1  editor requests the RAM port.
- edit_addr  in  2  row address the editor wants.
- edit_gnt  out  1  editor owns the RAM port this cycle.
- RamAddr  out  2  board RAM row address.
- RamDat  in  24  RAM read data. Bits [23:20] write-protect (ignored). Bits [19:16] blank flags, bit i = column i. Bits [15:0] digits, column i at [4i+3:4i].
- busy  out  1  a scan is in progress or pending.
- done  out  1  one-cycle pulse: scan finished, results valid.
- gameComplete  out  1  last completed scan found a solved board.
- rowErr  out  4  bit r set = row r failed its row check in the last completed scan.

## Operation
- RAM read latency is 1 cycle: data for the address driven in cycle t appears on RamDat in cycle t+1.
- Arbitration:
  - edit_gnt = edit_req & ~RST, combinational.
  - While edit_gnt is high, RamAddr = edit_addr.
  - Otherwise RamAddr = the scan row while scanning, else 0.
- States:
  - IDLE: busy=0. start (or AUTO_RESCAN after done) → SCAN with row=0.
  - SCAN: drive row 0..3 on RamAddr, one per cycle. Capture data for the previous row. After row 3 is issued → DRAIN.
  - DRAIN: capture row 3 → EVAL.
  - EVAL: register results, pulse done → IDLE.
  - HOLD: scan suspended for an editor access.
- Edit during scan:
  - Any edit_gnt cycle while busy aborts the scan, discards all accumulators and enters HOLD.
  - In the first cycle edit_req is low, HOLD re-issues row 0 (same as SCAN entry).
  - Data returned the cycle after an editor-owned cycle is never captured.
- Start handling:
  - start while busy is ignored.
  - start together with edit_req is latched. busy=1, and the scan begins in the first cycle edit_req is low.
- Every edit_gnt cycle clears gameComplete to 0 on the next edge, since the board may have changed. rowErr holds its value.
- Per-row check:
  - A digit is valid if its value is 1..4 and its blank flag is 0.
  - onehot(d) = 1<<(d-1).
  - The row passes if all four digits are valid and the OR of their onehots = 4'b1111.
- Accumulators, cleared at scan start:
  - colMask[c] |= onehot(digit c).
  - boxMask[{row[1],c[1]}] |= onehot(digit c).
  - Invalid digits contribute 0.
- EVAL:
  - gameComplete = all rows pass & every colMask = 4'b1111 & every boxMask = 4'b1111.
  - rowErr = per-row fail bits.

## Timing
- Reset values (asserting RST mid-scan also forces these next cycle, state IDLE, all accumulators and latched start cleared):
  - busy=0, done=0, gameComplete=0, rowErr=0, RamAddr=0.
  - edit_gnt=0 while RST is high.
- start sampled high at edge k with no edits:
  - busy=1 from k+1.
  - RamAddr = 0,1,2,3 during cycles k+1..k+4.
  - Captures occur in k+2..k+5.
  - done=1 and gameComplete/rowErr updated in cycle k+6; busy=0 in k+6.
  - Latency is 6 cycles.
- Results are stable from done until the next EVAL. Exception: gameComplete is cleared by an edit grant.
- AUTO_RESCAN=1: busy rises again in k+7 and the next scan's row 0 is issued in k+7.
- An edit grant in the same cycle as EVAL is allowed: done still pulses, and gameComplete is 0 in the following cycle.

## Test plan
- Solved board 1234/3412/2143/4321, all blank flags 0, start at k: RamAddr 0,1,2,3 at k+1..k+4; done, gameComplete=1, rowErr=0000 at k+6; busy low at k+6.
- Same board with row 2 blank flag bit 1 set: gameComplete=0, rowErr=0100.
- Rows all 1234: every row passes, columns fail → gameComplete=0, rowErr=0000.
  - Also rows 1234/2341/3412/4123: rows and columns pass, box 0 = {1,2,2,3} → gameComplete=0, rowErr=0000.
- Digit value 0 in row 0 col 0, then value 5: each gives rowErr=0001, gameComplete=0.
- Edit during scan: start at k, edit_req=1 with edit_addr=2 at k+3,k+4.
  - edit_gnt=1 and RamAddr=2 in both cycles.
  - Row 0 re-issued at k+5, rows 0..3 at k+5..k+8, done at k+10 with correct result.
  - A prior gameComplete=1 is cleared from k+4.
- Reset mid-scan at k+3: all outputs 0 at k+4, no done pulse. start during RST is ignored; start afterwards scans normally.

Source files
------------

// File: rtl/sudoku_scan_ctrl.sv
// sudoku_scan_ctrl: 4x4 Sudoku board scanner and board-RAM address-port arbiter (editor has priority).
// Ports: CLK/RST clock and sync active-high reset; start scan request; edit_req/edit_addr/edit_gnt
// editor port request, row and grant; RamAddr/RamDat board RAM row address and 1-cycle-latency read data;
// busy scan running or pending; done one-cycle result pulse; gameComplete solved flag; rowErr per-row failures.
module sudoku_scan_ctrl #(
  parameter bit AUTO_RESCAN = 1'b0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic        edit_req,
  input  logic [1:0]  edit_addr,
  output logic        edit_gnt,
  output logic [1:0]  RamAddr,
  input  logic [23:0] RamDat,
  output logic        busy,
  output logic        done,
  output logic        gameComplete,
  output logic [3:0]  rowErr
);
  typedef enum logic [2:0] {IDLE, SCAN, DRAIN, EVAL, HOLD} state_t;
  state_t state, state_n;
  logic [1:0] row, cap_row;
  logic cap, issue, scanning, go, row_pass, gc_n, unused_wp;
  logic [3:0] vld, fail, fail_n, seen;
  logic [3:0][3:0] oh, col_mask, box_mask, col_n, box_n;

  assign unused_wp = ^RamDat[23:20];

  always_ff @(posedge CLK) state <= RST ? IDLE : state_n;

  // A scan request that coincides with an editor grant waits in HOLD, which then issues row 0 itself.
  always_comb begin
    go = start | (AUTO_RESCAN && state == EVAL);
    state_n = IDLE;
    case (state)
      IDLE, EVAL: state_n = go ? (edit_gnt ? HOLD : SCAN) : IDLE;
      SCAN:       state_n = edit_gnt ? HOLD : (row == 2'd3 ? DRAIN : SCAN);
      HOLD:       state_n = edit_gnt ? HOLD : SCAN;
      DRAIN:      state_n = edit_gnt ? HOLD : EVAL;
      default:    state_n = IDLE;
    endcase
  end

  always_comb begin
    edit_gnt = edit_req & ~RST;
    scanning = state == SCAN || state == HOLD;
    issue = scanning & ~edit_gnt;
    busy = scanning || state == DRAIN;
    done = state == EVAL;
    RamAddr = edit_gnt ? edit_addr : (issue & ~RST) ? row : 2'd0;
  end

  // Digit d in 1..4 maps to onehot 1<<(d-1); its low two bits minus one give the shift (4 wraps to 3).
  always_comb begin
    vld = '0;
    oh = '0;
    seen = '0;
    col_n = col_mask;
    box_n = box_mask;
    fail_n = fail;
    for (int c = 0; c < 4; c++) begin
      vld[c] = ~RamDat[16+c] && RamDat[4*c +: 4] >= 4'd1 && RamDat[4*c +: 4] <= 4'd4;
      oh[c] = vld[c] ? 4'b1 << (RamDat[4*c +: 2] - 2'd1) : 4'b0;
      seen = seen | oh[c];
    end
    row_pass = &vld && &seen;
    if (cap) begin
      for (int c = 0; c < 4; c++) begin
        col_n[c] = col_mask[c] | oh[c];
        box_n[{cap_row[1], c[1]}] = box_n[{cap_row[1], c[1]}] | oh[c];
      end
      fail_n[cap_row] = fail[cap_row] | ~row_pass;
    end
    gc_n = ~|fail_n && &col_n && &box_n;
  end

  // cap marks that last cycle drove a scan row, so RamDat now holds that row; editor cycles never set it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      row <= '0;
      cap <= 1'b0;
      cap_row <= '0;
      col_mask <= '0;
      box_mask <= '0;
      fail <= '0;
      gameComplete <= 1'b0;
      rowErr <= '0;
    end else begin
      row <= issue ? row + 2'd1 : 2'd0;
      cap <= issue;
      cap_row <= row;
      col_mask <= (busy && !edit_gnt) ? col_n : '0;
      box_mask <= (busy && !edit_gnt) ? box_n : '0;
      fail <= (busy && !edit_gnt) ? fail_n : '0;
      gameComplete <= edit_gnt ? 1'b0 : (state == DRAIN) ? gc_n : gameComplete;
      rowErr <= (state == DRAIN && !edit_gnt) ? fail_n : rowErr;
    end
  end
endmodule

// File: tb/tb_sudoku_scan_ctrl.sv
// tb_sudoku_scan_ctrl: scoreboard bench for sudoku_scan_ctrl with a set-based reference model of the board rules.
module tb_sudoku_scan_ctrl;
  logic CLK = 1'b0, RST = 1'b1, start = 1'b0, edit_req = 1'b0;
  logic [1:0] edit_addr = 2'd0;
  logic edit_gnt, busy, done, gameComplete;
  logic [1:0] RamAddr;
  logic [23:0] RamDat;
  logic [3:0] rowErr;
  logic [23:0] mem [4];
  logic prev_gnt = 1'b0;
  int checks = 0, errors = 0;
  int base [4][4] = '{'{1, 2, 3, 4}, '{3, 4, 1, 2}, '{2, 1, 4, 3}, '{4, 3, 2, 1}};
  typedef struct packed {logic gc; logic [3:0] re;} exp_t;
  exp_t exp_q [$];

  sudoku_scan_ctrl dut (
    .CLK(CLK), .RST(RST), .start(start), .edit_req(edit_req), .edit_addr(edit_addr),
    .edit_gnt(edit_gnt), .RamAddr(RamAddr), .RamDat(RamDat), .busy(busy), .done(done),
    .gameComplete(gameComplete), .rowErr(rowErr)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) RamDat <= mem[RamAddr];

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [23:0] mk(int a, int b, int c, int d);
    return {8'h00, 4'(d), 4'(c), 4'(b), 4'(a)};
  endfunction

  // A group is good when it holds four usable digits that are pairwise different.
  function automatic bit grp_ok(int g[4]);
    for (int i = 0; i < 4; i++) begin
      if (g[i] == 0) return 1'b0;
      for (int j = i + 1; j < 4; j++) if (g[i] == g[j]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic exp_t model(input logic [23:0] b [4]);
    int v [4][4];
    int g [4];
    int d;
    exp_t e;
    e.gc = 1'b1;
    e.re = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        d = int'(b[r][4*c +: 4]);
        v[r][c] = (!b[r][16+c] && d >= 1 && d <= 4) ? d : 0;
      end
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) g[c] = v[r][c];
      if (!grp_ok(g)) begin e.re[r] = 1'b1; e.gc = 1'b0; end
    end
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) g[r] = v[r][c];
      if (!grp_ok(g)) e.gc = 1'b0;
    end
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 4; i++) g[i] = v[(k / 2) * 2 + i / 2][(k % 2) * 2 + i % 2];
      if (!grp_ok(g)) e.gc = 1'b0;
    end
    return e;
  endfunction

  always @(negedge CLK) begin
    exp_t e;
    chk("edit_gnt", int'(edit_gnt), int'(edit_req & ~RST));
    if (edit_gnt) chk("ram_addr_edit", int'(RamAddr), int'(edit_addr));
    if (prev_gnt) chk("gc_cleared_by_edit", int'(gameComplete), 0);
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 expected=0 at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        chk("gameComplete", int'(gameComplete), int'(e.gc));
        chk("rowErr", int'(rowErr), int'(e.re));
        chk("busy_at_done", int'(busy), 0);
      end
    end
    prev_gnt = edit_gnt;
  end

  task automatic load_base();
    for (int r = 0; r < 4; r++) mem[r] = mk(base[r][0], base[r][1], base[r][2], base[r][3]);
  endtask

  task automatic rand_board();
    int p [4];
    int g [4][4];
    int t, j, r, c;
    logic [3:0] x;
    p = '{1, 2, 3, 4};
    for (int i = 3; i > 0; i--) begin
      j = $urandom_range(i, 0);
      t = p[i]; p[i] = p[j]; p[j] = t;
    end
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++) g[a][b] = p[base[a][b] - 1];
    for (int k = 0; k < 2; k++) begin
      if ($urandom_range(1) == 1)
        for (int q = 0; q < 4; q++) begin t = g[2*k][q]; g[2*k][q] = g[2*k+1][q]; g[2*k+1][q] = t; end
      if ($urandom_range(1) == 1)
        for (int q = 0; q < 4; q++) begin t = g[q][2*k]; g[q][2*k] = g[q][2*k+1]; g[q][2*k+1] = t; end
    end
    for (int a = 0; a < 4; a++)
      mem[a] = {4'($urandom), 4'h0, 4'(g[a][3]), 4'(g[a][2]), 4'(g[a][1]), 4'(g[a][0])};
    repeat ($urandom_range(2)) begin
      r = $urandom_range(3);
      c = $urandom_range(3);
      case ($urandom_range(2))
        0: mem[r][4*c +: 4] = 4'($urandom);
        1: mem[r][16+c] = 1'b1;
        default: begin
          x = mem[r][4*c +: 4];
          mem[r][4*c +: 4] = mem[r][4*(c^1) +: 4];
          mem[r][4*(c^1) +: 4] = x;
        end
      endcase
    end
  endtask

  task automatic scan(input int pct);
    bit seen = 1'b0;
    @(posedge CLK); #1;
    start = 1'b1;
    edit_req = $urandom_range(99) < pct;
    edit_addr = 2'($urandom_range(3));
    exp_q.push_back(model(mem));
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge CLK); #1;
      start = 1'b0;
      edit_req = (i < 20) && ($urandom_range(99) < pct);
      edit_addr = 2'($urandom_range(3));
      @(negedge CLK);
      seen = done;
    end
    chk("scan_done_seen", int'(seen), 1);
    @(posedge CLK); #1;
    edit_req = 1'b0;
  endtask

  initial begin
    for (int r = 0; r < 4; r++) mem[r] = '0;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_gc", int'(gameComplete), 0);
    chk("rst_rowErr", int'(rowErr), 0);
    chk("rst_RamAddr", int'(RamAddr), 0);

    // solved board: address sequence, busy window, 6-cycle latency; start held while busy is ignored
    load_base();
    @(posedge CLK); #1;
    start = 1'b1;
    exp_q.push_back(model(mem));
    for (int i = 1; i <= 8; i++) begin
      @(posedge CLK); #1;
      start = i <= 2;
      @(negedge CLK);
      if (i <= 4) chk("scan_RamAddr", int'(RamAddr), i - 1);
      chk("scan_busy", int'(busy), int'(i < 6));
      chk("scan_done", int'(done), int'(i == 6));
    end

    // editor takes the port at k+3,k+4: scan restarts from row 0 at k+5, done at k+10
    @(posedge CLK); #1;
    start = 1'b1;
    exp_q.push_back(model(mem));
    for (int i = 1; i <= 11; i++) begin
      @(posedge CLK); #1;
      start = 1'b0;
      edit_req = i == 3 || i == 4;
      edit_addr = 2'd2;
      @(negedge CLK);
      if (i == 3 || i == 4) chk("edit_RamAddr", int'(RamAddr), 2);
      if (i >= 5 && i <= 8) chk("rescan_RamAddr", int'(RamAddr), i - 5);
      if (i == 3) chk("gc_before_edit", int'(gameComplete), 1);
      if (i == 4) chk("gc_after_edit", int'(gameComplete), 0);
      chk("edit_done", int'(done), int'(i == 10));
    end

    // reset in the middle of a scan; start and edit_req during reset are ignored
    @(posedge CLK); #1;
    start = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(posedge CLK); #1;
      start = i == 3;
      RST = i == 3;
      edit_req = i == 3;
      if (i == 3) exp_q.delete();
      @(negedge CLK);
      if (i == 3) chk("rst_edit_gnt", int'(edit_gnt), 0);
    end
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_gc", int'(gameComplete), 0);
    chk("midrst_rowErr", int'(rowErr), 0);
    chk("midrst_RamAddr", int'(RamAddr), 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      chk("idle_after_rst", int'(busy), 0);
    end
    scan(0);

    // editor grant during the done cycle: done still pulses, gameComplete drops the cycle after
    @(posedge CLK); #1;
    start = 1'b1;
    exp_q.push_back(model(mem));
    for (int i = 1; i <= 7; i++) begin
      @(posedge CLK); #1;
      start = 1'b0;
      edit_req = i == 6;
      edit_addr = 2'd1;
      @(negedge CLK);
      if (i == 6) chk("eval_edit_done", int'(done), 1);
      if (i == 7) chk("eval_edit_gc", int'(gameComplete), 0);
    end
    @(posedge CLK); #1;
    edit_req = 1'b0;

    load_base();
    mem[2][17] = 1'b1;
    scan(0);
    for (int r = 0; r < 4; r++) mem[r] = mk(1, 2, 3, 4);
    scan(0);
    mem[0] = mk(1, 2, 3, 4); mem[1] = mk(2, 3, 4, 1); mem[2] = mk(3, 4, 1, 2); mem[3] = mk(4, 1, 2, 3);
    scan(0);
    load_base();
    mem[0][3:0] = 4'd0;
    scan(0);
    mem[0][3:0] = 4'd5;
    scan(0);

    for (int n = 0; n < 150; n++) begin
      rand_board();
      scan(n < 40 ? 0 : 15);
    end

    repeat (5) @(negedge CLK);
    chk("pending_results", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
